// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic input skew feeder.
// Holds the feeder FSM state encoding, the drain-length helper and the
// SIMD mode encodings that the feeder forwards unchanged to the PE array.
package systolic_skew_feeder_pkg;

    // Feeder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // SIMD mode encodings understood by the PE; the feeder only carries them
    typedef enum logic [1:0] {
        SIMD_1X16 = 2'd0,
        SIMD_2X8  = 2'd1,
        SIMD_4X4  = 2'd2,
        SIMD_RSVD = 2'd3
    } simd_mode_e;

    // Cycles after the last handshake until the far-corner PE has absorbed
    // its final operand pair: skew to the corner plus the MAC latency.
    function automatic int unsigned drain_len(input int unsigned arr_height,
                                              input int unsigned arr_width,
                                              input int unsigned pe_lat);
        return arr_height + arr_width - 2 + pe_lat;
    endfunction

endpackage : systolic_skew_feeder_pkg

// File: rtl/systolic_skew_feeder_delay.sv
// skew_delay_line: fixed-depth register delay line with async reset.
// Ports:
//   clk   - rising-edge clock
//   reset - async active-high, clears every stage
//   in    - WIDTH-bit sample entering stage 0
//   out   - WIDTH-bit sample leaving the last stage (registered)
module skew_delay_line #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned BITS = DEPTH * WIDTH;

    // Stage 0 sits in the least-significant WIDTH bits
    logic [BITS-1:0] shift_q;
    logic [BITS-1:0] shift_d;

    // Shift by one stage; the oldest stage falls off the top
    always_comb begin
        shift_d = BITS'({shift_q, in});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign out = shift_q[BITS-1 -: WIDTH];

endmodule : skew_delay_line

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: input staging in front of systolic_array.
// Accepts one K-step (A column + B row) per handshake, skews lane i / j by
// i / j cycles so that step k meets at every PE(i,j) in the same cycle,
// pushes zero bubbles when input stalls, drains with zeros after the last
// step and pulses done once the far-corner PE has absorbed its last pair.
// Ports:
//   clk, reset              - clock, async active-high reset
//   start, k_len, simd_mode - tile launch (sampled only in IDLE)
//   in_valid / in_ready     - K-step handshake
//   a_col, b_row            - packed A lanes (rows) and B lanes (columns)
//   out_a, out_b            - skewed operands to array west / north edges
//   SIMD_control            - latched SIMD mode, held until next tile
//   busy, done              - FEED/DRAIN indicator, completion pulse
module systolic_skew_feeder #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ARR_HEIGHT = 4,
    parameter int unsigned ARR_WIDTH  = 4,
    parameter int unsigned K_BITS     = 8,
    parameter int unsigned PE_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [K_BITS-1:0]             k_len,
    input  logic [1:0]                    simd_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ARR_HEIGHT*WIDTH-1:0]   a_col,
    input  logic [ARR_WIDTH*WIDTH-1:0]    b_row,
    output logic [ARR_HEIGHT*WIDTH-1:0]   out_a,
    output logic [ARR_WIDTH*WIDTH-1:0]    out_b,
    output logic [1:0]                    SIMD_control,
    output logic                          busy,
    output logic                          done
);

    import systolic_skew_feeder_pkg::*;

    localparam int unsigned D          = drain_len(ARR_HEIGHT, ARR_WIDTH, PE_LAT);
    localparam int unsigned DRAIN_BITS = (D < 2) ? 1 : $clog2(D + 1);

    state_e                  state_q,     state_d;
    logic [K_BITS-1:0]       k_len_q,     k_len_d;
    logic [K_BITS-1:0]       step_cnt_q,  step_cnt_d;
    logic [DRAIN_BITS-1:0]   drain_cnt_q, drain_cnt_d;
    logic [1:0]              simd_q,      simd_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // Lane values entering the delay lines this cycle (zero unless consumed)
    logic [ARR_HEIGHT*WIDTH-1:0] a_push;
    logic [ARR_WIDTH*WIDTH-1:0]  b_push;

    // Next-state, counters and lane selection
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        step_cnt_d  = step_cnt_q;
        drain_cnt_d = drain_cnt_q;
        simd_d      = simd_q;
        done_d      = 1'b0;
        a_push      = '0;
        b_push      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        k_len_d    = k_len;
                        simd_d     = simd_mode;
                        step_cnt_d = '0;
                        state_d    = FEED;
                    end else begin
                        // Empty tile completes without touching the array
                        done_d = 1'b1;
                    end
                end
            end

            FEED: begin
                // Without in_valid the zero defaults form the bubble
                if (in_valid) begin
                    a_push     = a_col;
                    b_push     = b_row;
                    step_cnt_d = step_cnt_q + K_BITS'(1);
                    if (step_cnt_q == k_len_q - K_BITS'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_BITS'(D);
                    end
                end
            end

            DRAIN: begin
                drain_cnt_d = drain_cnt_q - DRAIN_BITS'(1);
                if (drain_cnt_q == DRAIN_BITS'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags track the state being entered so they stay registered
        in_ready_d = (state_d == FEED);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            step_cnt_q  <= '0;
            drain_cnt_q <= '0;
            simd_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            step_cnt_q  <= step_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            simd_q      <= simd_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign SIMD_control = simd_q;

    // A lane i is delayed i+1 cycles; the last stage drives out_a directly
    for (genvar gi = 0; gi < ARR_HEIGHT; gi++) begin : g_a_skew
        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (gi + 1)
        ) u_a_line (
            .clk   (clk),
            .reset (reset),
            .in    (a_push[gi*WIDTH +: WIDTH]),
            .out   (out_a[gi*WIDTH +: WIDTH])
        );
    end

    // B lane j is delayed j+1 cycles
    for (genvar gj = 0; gj < ARR_WIDTH; gj++) begin : g_b_skew
        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (gj + 1)
        ) u_b_line (
            .clk   (clk),
            .reset (reset),
            .in    (b_push[gj*WIDTH +: WIDTH]),
            .out   (out_b[gj*WIDTH +: WIDTH])
        );
    end

endmodule : systolic_skew_feeder

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (4x4 array, 16-bit lanes).
// Outputs are recorded once per cycle, just after the rising edge; a small
// output-stationary systolic model replays them to rebuild C = A^T * B.
module tb_systolic_skew_feeder;

    localparam int unsigned W   = 16;
    localparam int unsigned AH  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned KB  = 8;
    localparam int unsigned LAT = 1;
    localparam int          DR  = 7;   // 4 + 4 - 2 + 1, worked out by hand
    localparam int          HN  = 64;

    logic              clk;
    logic              reset;
    logic              start;
    logic [KB-1:0]     k_len;
    logic [1:0]        simd_mode;
    logic              in_valid;
    logic              in_ready;
    logic [AH*W-1:0]   a_col;
    logic [AW*W-1:0]   b_row;
    logic [AH*W-1:0]   out_a;
    logic [AW*W-1:0]   out_b;
    logic [1:0]        SIMD_control;
    logic              busy;
    logic              done;

    systolic_skew_feeder #(
        .WIDTH      (W),
        .ARR_HEIGHT (AH),
        .ARR_WIDTH  (AW),
        .K_BITS     (KB),
        .PE_LAT     (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .k_len        (k_len),
        .simd_mode    (simd_mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_col        (a_col),
        .b_row        (b_row),
        .out_a        (out_a),
        .out_b        (out_b),
        .SIMD_control (SIMD_control),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0]    a_tab  [0:15][0:AH-1];
    logic [W-1:0]    b_tab  [0:15][0:AW-1];
    logic [AH*W-1:0] hist_a [0:HN-1];
    logic [AW*W-1:0] hist_b [0:HN-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_step(input int s);
        for (int i = 0; i < AH; i++) a_col[i*W +: W] = a_tab[s][i];
        for (int j = 0; j < AW; j++) b_row[j*W +: W] = b_tab[s][j];
    endtask

    task automatic drive_garbage();
        a_col = {AH{16'hDEAD}};
        b_row = {AW{16'hBEEF}};
    endtask

    function automatic logic [W-1:0] lane_a(input int c, input int i);
        logic [AH*W-1:0] v;
        v = hist_a[c];
        return v[i*W +: W];
    endfunction

    function automatic logic [W-1:0] lane_b(input int c, input int j);
        logic [AW*W-1:0] v;
        v = hist_b[c];
        return v[j*W +: W];
    endfunction

    // Launch a tile and run it for a fixed window. A stall of stall_len
    // bubbles is inserted before step stall_pos. In noisy mode start stays
    // high with another SIMD mode and in_valid is held high with junk once
    // the steps are used up, both of which must be ignored.
    task automatic run_tile(input int k, input logic [1:0] mode, input int stall_pos,
                            input int stall_len, input bit noisy,
                            output int done_cyc, output int done_cnt, output int simd_bad);
        int step, bub, c, limit;
        for (int h = 0; h < HN; h++) begin
            hist_a[h] = '0;
            hist_b[h] = '0;
        end
        start = 1'b1; k_len = KB'(k); simd_mode = mode; in_valid = 1'b0;
        drive_garbage();
        tick();
        if (noisy) simd_mode = 2'd2;
        else       start = 1'b0;
        check("feed_in_ready", in_ready, 1'b1);
        check("feed_busy", busy, 1'b1);
        c = 0; step = 0; bub = 0;
        done_cyc = -1; done_cnt = 0; simd_bad = 0;
        limit = k + stall_len + DR + 2;
        hist_a[0] = out_a;
        hist_b[0] = out_b;
        while (c < limit) begin
            if (noisy && c >= k + 2) start = 1'b0;
            if (step < k && !(step == stall_pos && bub < stall_len)) begin
                in_valid = 1'b1;
                drive_step(step);
                step++;
            end else begin
                if (step < k) bub++;
                in_valid = noisy;
                drive_garbage();
            end
            tick();
            c++;
            hist_a[c] = out_a;
            hist_b[c] = out_b;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (SIMD_control !== mode) simd_bad++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Replay the recorded edge streams through an ideal output-stationary
    // array: A moves east and B moves south one PE per cycle.
    task automatic check_mm(input string tag, input int k);
        logic [63:0] ref_c, sim_c;
        for (int i = 0; i < AH; i++) begin
            for (int j = 0; j < AW; j++) begin
                ref_c = '0;
                sim_c = '0;
                for (int s = 0; s < k; s++) ref_c += 64'(a_tab[s][i]) * 64'(b_tab[s][j]);
                for (int c = 0; c < HN; c++) begin
                    if (c >= i && c >= j)
                        sim_c += 64'(lane_a(c - j, i)) * 64'(lane_b(c - i, j));
                end
                check($sformatf("%s_c%0d%0d", tag, i, j), sim_c, ref_c);
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ready"}, in_ready, 1'b0);
        check({tag, "_out_a"}, out_a, '0);
        check({tag, "_out_b"}, out_b, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, dn, sb;
        reset = 1'b1; start = 1'b0; k_len = '0; simd_mode = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0;
        tick(); tick();
        check("rst_out_a", out_a, '0);
        check("rst_out_b", out_b, '0);
        check("rst_simd", SIMD_control, 2'd0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        tick();

        // Step s: A lanes {1,2,3,4}+16s, B lanes {5,6,7,8}+16s
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < AH; i++) a_tab[s][i] = W'(i + 1 + 16 * s);
            for (int j = 0; j < AW; j++) b_tab[s][j] = W'(j + 5 + 16 * s);
        end

        // Basic tile, valid every cycle. Counting the first handshake cycle
        // as cycle 1, done lands on cycle 3+7+1, i.e. index 10 from it.
        run_tile(3, 2'd1, -1, 0, 1'b0, dc, dn, sb);
        check("t1_a3_at4", lane_a(4, 3), 16'd4);
        check("t1_a3_at3", lane_a(3, 3), 16'd0);
        check("t1_a2_at3", lane_a(3, 2), 16'd3);
        check("t1_b0_at1", lane_b(1, 0), 16'd5);
        check("t1_b3_at4", lane_b(4, 3), 16'd8);
        check("t1_done_cnt", dn, 1);
        check("t1_done_cyc", dc, 10);
        check("t1_simd", sb, 0);
        check_mm("t1_mm", 3);
        check_quiet("t1_end");

        // Two bubbles before step 1 (input cycles 1 and 2)
        run_tile(3, 2'd1, 1, 2, 1'b0, dc, dn, sb);
        check("t2_a0_at2", lane_a(2, 0), 16'd0);
        check("t2_a0_at3", lane_a(3, 0), 16'd0);
        check("t2_a0_at4", lane_a(4, 0), 16'd17);
        check("t2_a3_at5", lane_a(5, 3), 16'd0);
        check("t2_a3_at6", lane_a(6, 3), 16'd0);
        check("t2_b1_at3", lane_b(3, 1), 16'd0);
        check("t2_b1_at4", lane_b(4, 1), 16'd0);
        check("t2_done_cnt", dn, 1);
        check("t2_done_cyc", dc, 12);
        check_mm("t2_mm", 3);

        // Zero-length tile: done next cycle, never busy, mode not latched
        start = 1'b1; k_len = '0; simd_mode = 2'd3;
        tick();
        start = 1'b0;
        check("t3_done", done, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_ready", in_ready, 1'b0);
        check("t3_simd", SIMD_control, 2'd1);
        tick();
        check("t3_done_drop", done, 1'b0);
        check_quiet("t3_end");

        // Reset in DRAIN aborts at once and clears the delay lines
        start = 1'b1; k_len = 8'd2; simd_mode = 2'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; drive_step(0); tick();
        drive_step(1); tick();
        in_valid = 1'b0; drive_garbage(); tick(); tick();
        check("t4_busy_drain", busy, 1'b1);
        check("t4_a3_pre", out_a[3*W +: W], 16'd4);
        reset = 1'b1;
        #1;
        check("t4_rst_out_a", out_a, '0);
        check("t4_rst_out_b", out_b, '0);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_simd", SIMD_control, 2'd0);
        check("t4_rst_ready", in_ready, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t4_no_done", done, 1'b0);
        end
        reset = 1'b0;
        tick();
        check("t4_post_done", done, 1'b0);

        // Clean tile after the abort, random operands
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < AH; i++) a_tab[s][i] = W'($urandom_range(0, 1000));
            for (int j = 0; j < AW; j++) b_tab[s][j] = W'($urandom_range(0, 1000));
        end
        run_tile(4, 2'd1, -1, 0, 1'b0, dc, dn, sb);
        check("t5_done_cnt", dn, 1);
        check("t5_done_cyc", dc, 11);
        check_mm("t5_mm", 4);

        // start / in_valid while busy with mode 2 must be ignored
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < AH; i++) a_tab[s][i] = W'(i + 1 + 16 * s);
            for (int j = 0; j < AW; j++) b_tab[s][j] = W'(j + 5 + 16 * s);
        end
        run_tile(3, 2'd1, -1, 0, 1'b1, dc, dn, sb);
        check("t6_simd", sb, 0);
        check("t6_done_cnt", dn, 1);
        check("t6_done_cyc", dc, 10);
        check_mm("t6_mm", 3);
        in_valid = 1'b1;
        drive_garbage();
        for (int n = 0; n < 6; n++) tick();
        in_valid = 1'b0;
        check_quiet("t6_idle");

        // Back-to-back random tiles
        for (int t = 0; t < 2; t++) begin
            int kk;
            kk = (t == 0) ? 5 : 8;
            for (int s = 0; s < kk; s++) begin
                for (int i = 0; i < AH; i++) a_tab[s][i] = W'($urandom_range(0, 4095));
                for (int j = 0; j < AW; j++) b_tab[s][j] = W'($urandom_range(0, 4095));
            end
            run_tile(kk, 2'(t), -1, 0, 1'b0, dc, dn, sb);
            check($sformatf("t7_%0d_done_cyc", t), dc, kk + DR);
            check($sformatf("t7_%0d_simd", t), sb, 0);
            check_mm($sformatf("t7_%0d_mm", t), kk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_systolic_skew_feeder
